// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared types and constants for the pipeline hold/flush sequencer.
// Hold encodings and pipeline halt states match the core-wide defines.
package pipe_hold_ctrl_pkg;

  localparam int unsigned HOLD_W  = 3;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned FLUSH_W = 2;
  localparam int unsigned STALL_W = 32;

  localparam logic [ADDR_W-1:0] ZERO_WORD = '0;

  typedef enum logic [HOLD_W-1:0] {
    HOLD_NONE = 3'd0,
    HOLD_PC   = 3'd1,
    HOLD_IF   = 3'd2,
    HOLD_ID   = 3'd3
  } hold_flag_e;

  typedef enum logic [1:0] {
    PIPE_RUN    = 2'd0,
    PIPE_DRAIN  = 2'd1,
    PIPE_HALTED = 2'd2
  } pipe_state_e;

  // Hold_If is kept in the encoding but never produced.
  function automatic hold_flag_e hold_encode(input logic id_req, input logic pc_req);
    hold_flag_e h;
    h = HOLD_NONE;
    if (id_req) begin
      h = HOLD_ID;
    end else if (pc_req) begin
      h = HOLD_PC;
    end
    return h;
  endfunction

endpackage

// File: rtl/pipe_hold_ctrl_if.sv
// Hold/jump/halt signal bundle between the core stages and pipe_hold_ctrl.
// Stall statistics ports exist only when PIPE_HOLD_STATS_EN is defined.
interface pipe_hold_ctrl_if import pipe_hold_ctrl_pkg::*; ();

  logic              jump_flag_i;
  logic [ADDR_W-1:0] jump_addr_i;
  logic              hold_flag_ex_i;
  logic              hold_flag_rib_i;
  logic              hold_flag_clint_i;
  logic              jtag_halt_req_i;
  logic [HOLD_W-1:0] hold_flag_o;
  logic              jump_flag_o;
  logic [ADDR_W-1:0] jump_addr_o;
  logic              jtag_halt_ack_o;
`ifdef PIPE_HOLD_STATS_EN
  logic               stall_cnt_clr_i;
  logic [STALL_W-1:0] stall_cnt_o;
`endif

  modport master (
    output jump_flag_i, jump_addr_i, hold_flag_ex_i, hold_flag_rib_i,
    output hold_flag_clint_i, jtag_halt_req_i,
`ifdef PIPE_HOLD_STATS_EN
    output stall_cnt_clr_i,
    input  stall_cnt_o,
`endif
    input  hold_flag_o, jump_flag_o, jump_addr_o, jtag_halt_ack_o
  );

  modport slave (
    input  jump_flag_i, jump_addr_i, hold_flag_ex_i, hold_flag_rib_i,
    input  hold_flag_clint_i, jtag_halt_req_i,
`ifdef PIPE_HOLD_STATS_EN
    input  stall_cnt_clr_i,
    output stall_cnt_o,
`endif
    output hold_flag_o, jump_flag_o, jump_addr_o, jtag_halt_ack_o
  );

endinterface

// File: rtl/pipe_hold_ctrl_halt_seq.sv
// Debug halt request/acknowledge sequencer: RUN -> DRAIN -> HALTED with a
// drain timeout that forces the halt if the pipeline never goes quiet.
module halt_seq import pipe_hold_ctrl_pkg::*; #(
  parameter int unsigned HALT_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic halt_req,
  input  logic ex_busy,
  input  logic flush_busy,
  input  logic jump,
  output logic halt_ack
);

  localparam int unsigned TMO_W = (HALT_TIMEOUT > 1) ? $clog2(HALT_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(HALT_TIMEOUT - 1);

  pipe_state_e      state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             ack_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= PIPE_RUN;
      tmo_q    <= '0;
      halt_ack <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      halt_ack <= ack_d;
    end
  end

  // A dropped request always beats drain completion.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    case (state_q)
      PIPE_RUN: begin
        if (halt_req) begin
          state_d = PIPE_DRAIN;
          tmo_d   = '0;
        end
      end
      PIPE_DRAIN: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (!halt_req) begin
          state_d = PIPE_RUN;
        end else if ((!ex_busy && !flush_busy && !jump) || (tmo_q == TMO_LAST)) begin
          state_d = PIPE_HALTED;
        end
      end
      PIPE_HALTED: begin
        if (!halt_req) begin
          state_d = PIPE_RUN;
        end
      end
      default: state_d = PIPE_RUN;
    endcase
    ack_d = (state_d == PIPE_HALTED);
  end

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush sequencer: priority hold encoder, jump flush stretcher
// and debug halt handshake. Define PIPE_HOLD_STATS_EN to add the stall counter.
module pipe_hold_ctrl import pipe_hold_ctrl_pkg::*; #(
  parameter int unsigned FLUSH_CYC    = 1,
  parameter int unsigned HALT_TIMEOUT = 16
) (
  input logic clk,
  input logic rst,
  pipe_hold_ctrl_if.slave bus
);

  logic [FLUSH_W-1:0] flush_cnt;
  logic               flush_busy_c;
  logic               halted;
  logic               hold_id_c;
  hold_flag_e         hold_c;

  assign bus.jump_flag_o = bus.jump_flag_i;
  assign bus.jump_addr_o = bus.jump_flag_i ? bus.jump_addr_i : ZERO_WORD;

  // A new jump reloads the flush window rather than extending it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_cnt <= '0;
    end else if (bus.jump_flag_i) begin
      flush_cnt <= FLUSH_W'(FLUSH_CYC);
    end else if (flush_cnt != '0) begin
      flush_cnt <= flush_cnt - FLUSH_W'(1);
    end
  end

  assign flush_busy_c = (flush_cnt != '0);

  // The registered ack is high exactly while the sequencer is HALTED.
  halt_seq #(
    .HALT_TIMEOUT(HALT_TIMEOUT)
  ) u_halt_seq (
    .clk        (clk),
    .rst        (rst),
    .halt_req   (bus.jtag_halt_req_i),
    .ex_busy    (bus.hold_flag_ex_i),
    .flush_busy (flush_busy_c),
    .jump       (bus.jump_flag_i),
    .halt_ack   (halted)
  );

  assign bus.jtag_halt_ack_o = halted;

  assign hold_id_c = bus.jump_flag_i | flush_busy_c | bus.hold_flag_ex_i
                   | bus.hold_flag_clint_i | halted;

  always_comb begin
    hold_c = hold_encode(hold_id_c, bus.hold_flag_rib_i);
  end

  assign bus.hold_flag_o = hold_c;

`ifdef PIPE_HOLD_STATS_EN
  logic [STALL_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (bus.stall_cnt_clr_i) begin
      stall_cnt_q <= '0;
    end else if ((hold_c != HOLD_NONE) && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + STALL_W'(1);
    end
  end

  assign bus.stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed plus randomized bench for pipe_hold_ctrl against a cycle-level
// behavioural model of the hold, flush and halt rules.
module tb_pipe_hold_ctrl;
  import pipe_hold_ctrl_pkg::*;

  localparam int unsigned FLUSH = 2;
  localparam int unsigned TMO   = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pipe_hold_ctrl_if bif();

  pipe_hold_ctrl #(
    .FLUSH_CYC    (FLUSH),
    .HALT_TIMEOUT (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: remaining flush cycles, halt progress, drain age.
  int m_flush;
  bit m_draining;
  bit m_halted;
  int m_age;
`ifdef PIPE_HOLD_STATS_EN
  longint m_stall;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_flush    = 0;
    m_draining = 1'b0;
    m_halted   = 1'b0;
    m_age      = 0;
`ifdef PIPE_HOLD_STATS_EN
    m_stall    = 0;
`endif
  endtask

  task automatic drive(input bit jf, input logic [31:0] addr, input bit ex,
                       input bit rib, input bit clint, input bit req);
    bif.jump_flag_i       = jf;
    bif.jump_addr_i       = addr;
    bif.hold_flag_ex_i    = ex;
    bif.hold_flag_rib_i   = rib;
    bif.hold_flag_clint_i = clint;
    bif.jtag_halt_req_i   = req;
  endtask

  function automatic logic [2:0] exp_hold();
    if (bif.jump_flag_i || m_flush > 0 || bif.hold_flag_ex_i ||
        bif.hold_flag_clint_i || m_halted) return 3'd3;
    if (bif.hold_flag_rib_i) return 3'd1;
    return 3'd0;
  endfunction

  // Check mid-cycle, then advance the model across one clock edge.
  task automatic step();
    logic [2:0] eh;
    int  n_flush;
    bit  n_draining, n_halted;
    int  n_age;
    #3;
    eh = exp_hold();
    check("hold_flag", 32'(bif.hold_flag_o), 32'(eh));
    check("jump_flag", 32'(bif.jump_flag_o), 32'(bif.jump_flag_i));
    check("jump_addr", bif.jump_addr_o, bif.jump_flag_i ? bif.jump_addr_i : 32'h0);
    check("halt_ack", 32'(bif.jtag_halt_ack_o), 32'(m_halted));
`ifdef PIPE_HOLD_STATS_EN
    check("stall_cnt", bif.stall_cnt_o, 32'(m_stall));
`endif
    n_flush    = bif.jump_flag_i ? int'(FLUSH) : ((m_flush > 0) ? m_flush - 1 : 0);
    n_draining = m_draining;
    n_halted   = m_halted;
    n_age      = m_age;
    if (m_halted) begin
      if (!bif.jtag_halt_req_i) n_halted = 1'b0;
    end else if (m_draining) begin
      if (!bif.jtag_halt_req_i) begin
        n_draining = 1'b0;
      end else if ((!bif.hold_flag_ex_i && m_flush == 0 && !bif.jump_flag_i) ||
                   m_age == int'(TMO) - 1) begin
        n_draining = 1'b0;
        n_halted   = 1'b1;
      end else begin
        n_age = m_age + 1;
      end
    end else if (bif.jtag_halt_req_i) begin
      n_draining = 1'b1;
      n_age      = 0;
    end
`ifdef PIPE_HOLD_STATS_EN
    if (bif.stall_cnt_clr_i) m_stall = 0;
    else if (eh != 3'd0 && m_stall < 64'hFFFF_FFFF) m_stall = m_stall + 1;
`endif
    @(posedge clk);
    #1;
    m_flush    = n_flush;
    m_draining = n_draining;
    m_halted   = n_halted;
    m_age      = n_age;
  endtask

  initial begin
    int cnt;
    drive(0, 32'h0, 0, 0, 0, 0);
`ifdef PIPE_HOLD_STATS_EN
    bif.stall_cnt_clr_i = 1'b0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Idle after reset.
    repeat (2) step();

    // Single jump pulse, flush stretched for FLUSH cycles.
    drive(1, 32'h0000_0100, 0, 0, 0, 0);
    step();
    drive(0, 32'h0000_0100, 0, 0, 0, 0);
    repeat (4) step();

    // Jump with rib busy, rib held through and after the flush.
    drive(1, 32'h0000_0200, 0, 1, 0, 0);
    step();
    drive(0, 32'h0, 0, 1, 0, 0);
    repeat (4) step();
    drive(0, 32'h0, 0, 0, 0, 0);
    step();

    // Halt requested while ex is busy, then ex frees up.
    drive(0, 32'h0, 1, 0, 0, 1);
    repeat (5) step();
    drive(0, 32'h0, 0, 0, 0, 1);
    repeat (3) step();
    check("halted_after_drain", 32'(bif.jtag_halt_ack_o), 32'd1);
    // Debugger pc write while halted.
    drive(1, 32'h0000_0400, 0, 0, 0, 1);
    step();
    drive(0, 32'h0, 0, 0, 0, 1);
    repeat (3) step();
    drive(0, 32'h0, 0, 0, 0, 0);
    repeat (2) step();
    check("ack_dropped", 32'(bif.jtag_halt_ack_o), 32'd0);

    // Timeout: ex stuck busy, ack must come 1 + TMO cycles after the request.
    drive(0, 32'h0, 1, 0, 0, 1);
    cnt = 0;
    while (bif.jtag_halt_ack_o !== 1'b1 && cnt < 40) begin
      step();
      cnt++;
    end
    check("halt_timeout_cycles", 32'(cnt), 32'(TMO + 1));

    // Asynchronous reset while halted clears ack without a clock edge.
    rst = 1'b0;
    #1;
    check("async_rst_ack", 32'(bif.jtag_halt_ack_o), 32'd0);
`ifdef PIPE_HOLD_STATS_EN
    check("async_rst_stall", bif.stall_cnt_o, 32'd0);
`endif
    model_reset();
    drive(0, 32'h0, 0, 0, 0, 0);
    #1;
    rst = 1'b1;
    step();

    // Seven held cycles, then a synchronous clear.
    drive(0, 32'h0, 1, 0, 0, 0);
    repeat (7) step();
`ifdef PIPE_HOLD_STATS_EN
    check("stall_seven", bif.stall_cnt_o, 32'd7);
    bif.stall_cnt_clr_i = 1'b1;
`endif
    drive(0, 32'h0, 1, 0, 0, 0);
    step();
`ifdef PIPE_HOLD_STATS_EN
    bif.stall_cnt_clr_i = 1'b0;
`endif
    drive(0, 32'h0, 0, 0, 0, 0);
    step();

    // Randomized traffic; the halt request toggles rarely so halts complete.
    for (int i = 0; i < 600; i++) begin
      bit req;
      req = bif.jtag_halt_req_i;
      if ($urandom_range(0, 19) == 0) req = ~req;
      drive($urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, req);
`ifdef PIPE_HOLD_STATS_EN
      bif.stall_cnt_clr_i = ($urandom_range(0, 49) == 0);
`endif
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hold_ctrl.md
Name: pipe_hold_ctrl

Overview:
- Central pipeline hold/flush sequencer for the core.
- Merges hold requests from ex (multi-cycle ops), rib (bus busy), clint (interrupt entry) and jtag (debug halt) into one priority-encoded hold_flag_o that drives pc_reg, if_id and id_ex.
- Stretches a jump into a registered multi-cycle flush, so the if_id and id_ex registers load NOP/zero defaults.
- Runs a jtag halt request/acknowledge handshake, with a drain phase and a timeout.

Parameters:
- FLUSH_CYC, 1, cycles of Hold_Id asserted after the cycle in which jump_flag_i is seen (legal range 1..3).
- HALT_TIMEOUT, 16, maximum DRAIN cycles before the halt is forced.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-low
- jump_flag_i  in  1  ex requests a jump this cycle
- jump_addr_i  in  32  jump target
- hold_flag_ex_i  in  1  ex multi-cycle op busy
- hold_flag_rib_i  in  1  bus busy; stall fetch only
- hold_flag_clint_i  in  1  clint interrupt sequencing
- jtag_halt_req_i  in  1  debug halt request (level)
- hold_flag_o  out  3  Hold_None/Hold_Pc/Hold_If/Hold_Id
- jump_flag_o  out  1  jump to pc_reg
- jump_addr_o  out  32  jump target to pc_reg
- jtag_halt_ack_o  out  1  core halted

Behaviour:
- Reset values (rst low, asynchronous): state RUN, flush_cnt 0, tmo_cnt 0, jtag_halt_ack_o 0. With all request inputs low, hold_flag_o = Hold_None, jump_flag_o = 0 and jump_addr_o = 0.
- jump_flag_o and jump_addr_o are combinational pass-through of the inputs, 0 latency. jump_addr_o = 0 when jump_flag_i = 0.
- flush_cnt is 2 bits.
  - jump_flag_i = 1 loads flush_cnt = FLUSH_CYC on the next edge.
  - Otherwise flush_cnt decrements while nonzero; it saturates at 0.
  - A jump arriving while flush_cnt != 0 reloads FLUSH_CYC; it does not accumulate.
- hold_flag_o is combinational; the highest level wins:
  - Hold_Id: jump_flag_i, or flush_cnt != 0, or hold_flag_ex_i, or hold_flag_clint_i, or state HALTED.
  - Hold_Pc: hold_flag_rib_i only.
  - Hold_None: otherwise.
  - Hold_If is never generated; the encoding is kept for compatibility.
- FSM states RUN, DRAIN, HALTED:
  - RUN -> DRAIN when jtag_halt_req_i = 1. tmo_cnt is cleared.
  - DRAIN -> HALTED when hold_flag_ex_i = 0 and flush_cnt = 0 and jump_flag_i = 0, or when tmo_cnt = HALT_TIMEOUT-1.
  - In DRAIN, tmo_cnt increments by 1 per cycle. Width is clog2(HALT_TIMEOUT).
  - DRAIN -> RUN if jtag_halt_req_i drops before the halt completes. No ack is issued.
  - HALTED: jtag_halt_ack_o = 1 (registered, asserted from the first HALTED cycle) and hold_flag_o = Hold_Id.
  - HALTED -> RUN on the edge after jtag_halt_req_i = 0. Ack drops in the same cycle the state returns to RUN.
- Jump while HALTED (pc write by the debugger) passes through and reloads flush_cnt. The state stays HALTED.
- Simultaneous jump and rib busy: Hold_Id wins.
- Simultaneous drain completion and req drop: req drop wins (-> RUN).
- Reset asserted mid-DRAIN or mid-HALTED returns to RUN immediately; the ack is cleared asynchronously.

Optional Feature:
- Macro: PIPE_HOLD_STATS_EN.
- Defined:
  - Adds output stall_cnt_o[31:0]. It increments every cycle hold_flag_o != Hold_None and saturates at 0xFFFFFFFF.
  - Adds input stall_cnt_clr_i. It clears the count synchronously and takes priority over increment.
  - stall_cnt_o resets to 0.
- Undefined: both ports and the counter are absent. Hold and halt behaviour are identical in both builds.

Decomposition:
- defines.v already supplies Hold_Flag_Bus, Hold_None/Hold_Pc/Hold_If/Hold_Id, InstAddrBus and ZeroWord.
- Add to defines.v: the state encodings PIPE_RUN = 2'd0, PIPE_DRAIN = 2'd1, PIPE_HALTED = 2'd2.
- Sub-module: the halt handshake FSM with its timeout counter as halt_seq. The flush counter and priority encoder stay in the top.

Test Plan:
- Reset, then idle with all inputs 0 -> hold_flag_o = 0, ack = 0, jump_flag_o = 0.
- jump_flag_i pulse 1 cycle with addr 0x0000_0100, FLUSH_CYC = 2 -> jump_addr_o = 0x100 in the pulse cycle; hold_flag_o = Hold_Id for 3 cycles total, then Hold_None.
- hold_flag_rib_i = 1 with a jump in the same cycle -> Hold_Id; next cycle with rib still 1 and flush active -> Hold_Id; after the flush ends -> Hold_Pc.
- jtag_halt_req_i = 1 while hold_flag_ex_i = 1 for 5 cycles -> DRAIN for 5 cycles, HALTED on the 6th edge, ack = 1, hold_flag_o = Hold_Id; drop req -> ack 0 next cycle, RUN.
- jtag_halt_req_i = 1 with hold_flag_ex_i stuck at 1, HALT_TIMEOUT = 16 -> ack asserts exactly 16 cycles after entering DRAIN.
- Async rst low while HALTED -> ack = 0 immediately without a clock. With PIPE_HOLD_STATS_EN, stall_cnt_o = 0 immediately; after 7 held cycles it reads 7, and stall_cnt_clr_i -> 0.
